// File: rtl/dbridge_pkg.sv
// Shared types for the M-stage data-memory bridge: FSM states, bus size codes, counter width.
package dbridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_DONE,
    ST_DRAIN
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/dbridge_perf_cnt.sv
// Saturating read/write/stall event counters for the data bridge.
// Compiled only when DBRIDGE_PERF_CNT_EN is defined.
`ifdef DBRIDGE_PERF_CNT_EN
module dbridge_perf_cnt
  import dbridge_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             rd_inc,
  input  logic             wr_inc,
  input  logic             stall_inc,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (rd_inc && (rd_cnt != CNT_MAX))       rd_cnt    <= rd_cnt + CNT_W'(1);
      if (wr_inc && (wr_cnt != CNT_MAX))       wr_cnt    <= wr_cnt + CNT_W'(1);
      if (stall_inc && (stall_cnt != CNT_MAX)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/data_sram_like_bridge.sv
// Turns each M-stage data access into one SRAM-like bus transaction and stalls until done.
// Optional perf counters when DBRIDGE_PERF_CNT_EN is defined.
module data_sram_like_bridge
  import dbridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        readEnM,
  input  logic [3:0]        writeEnM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] writedata_decodedM,
  input  logic [1:0]        size,
  input  logic              flush_except,
  input  logic              longest_stall,
  output logic [DATA_W-1:0] readdataM,
  output logic              stallreq_from_mem,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
`ifdef DBRIDGE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  perf_rd_cnt,
  output logic [CNT_W-1:0]  perf_wr_cnt,
  output logic [CNT_W-1:0]  perf_stall_cnt
`endif
);

  state_t state, state_next;
  logic   abort, abort_next;
  logic   access, discard, complete;

  assign access  = (|readEnM | |writeEnM) & ~flush_except;
  assign discard = abort | flush_except;

  // Next state; an abort seen while the request is outstanding turns the result into a drain.
  always_comb begin
    state_next = state;
    abort_next = 1'b0;
    complete   = 1'b0;
    case (state)
      ST_IDLE: if (access) state_next = ST_ADDR;
      ST_ADDR: begin
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_next = discard ? ST_IDLE : ST_DONE;
            complete   = ~discard;
          end else begin
            state_next = discard ? ST_DRAIN : ST_DATA;
          end
        end else begin
          abort_next = discard;
        end
      end
      ST_DATA: begin
        if (data_data_ok) begin
          state_next = discard ? ST_IDLE : ST_DONE;
          complete   = ~discard;
        end else if (flush_except) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DONE:  if (flush_except | ~longest_stall) state_next = ST_IDLE;
      ST_DRAIN: if (data_data_ok) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign stallreq_from_mem = ((state == ST_IDLE) & access) | (state == ST_ADDR) |
                             (state == ST_DATA) | (state == ST_DRAIN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      abort    <= 1'b0;
      data_req <= 1'b0;
    end else begin
      state    <= state_next;
      abort    <= abort_next;
      data_req <= (state_next == ST_ADDR);
    end
  end

  // Request fields are frozen for the whole transaction.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_wr    <= 1'b0;
      data_size  <= SZ_BYTE;
      data_addr  <= '0;
      data_wdata <= '0;
    end else if ((state == ST_IDLE) && access) begin
      data_wr    <= |writeEnM;
      data_size  <= size;
      data_addr  <= aluoutM;
      data_wdata <= writedata_decodedM;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      readdataM <= '0;
    end else if (complete && !data_wr) begin
      readdataM <= data_rdata;
    end
  end

`ifdef DBRIDGE_PERF_CNT_EN
  dbridge_perf_cnt u_perf_cnt (
    .clk       (clk),
    .rst       (rst),
    .rd_inc    (complete & ~data_wr),
    .wr_inc    (complete & data_wr),
    .stall_inc (stallreq_from_mem),
    .rd_cnt    (perf_rd_cnt),
    .wr_cnt    (perf_wr_cnt),
    .stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: doc/data_sram_like_bridge.md
Name: data_sram_like_bridge

Overview:
Responder for the M-stage data-memory request that the pipeline datapath issues. Inputs per request: read/write byte enables, address, decoded write data, size.
Converts each request into a single transaction on the SRAM-like data bus (req/addr_ok/data_ok). Stalls the pipeline through stallreq_from_mem until the transaction completes. Returns registered read data to the M stage.
Sits between the datapath M stage and the AXI/SRAM-like bus interface.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
readEnM  input  4  byte read enables from M stage
writeEnM  input  4  byte write enables from M stage
aluoutM  input  ADDR_W  request address
writedata_decodedM  input  DATA_W  byte-lane-aligned write data
size  input  2  0=byte, 1=half, 2=word
flush_except  input  1  exception flush; suppresses/aborts current request
longest_stall  input  1  pipeline stall from any other source
readdataM  output  DATA_W  captured read data
stallreq_from_mem  output  1  stall request to hazard unit
data_req  output  1  bus request valid
data_wr  output  1  1=write
data_size  output  2  bus size
data_addr  output  ADDR_W  bus address
data_wdata  output  DATA_W  bus write data
data_addr_ok  input  1  address accepted
data_data_ok  input  1  data phase complete
data_rdata  input  DATA_W  bus read data

Behaviour:
- access = (|readEnM | |writeEnM) & ~flush_except.
- States: IDLE, ADDR, DATA, DONE, DRAIN.
- IDLE -> ADDR when access.
  - On this edge, latch wr=|writeEnM, data_size, data_addr, data_wdata; fields hold constant until the next IDLE->ADDR.
- ADDR: data_req=1, held high until data_addr_ok; req is never withdrawn.
  - addr_ok & data_ok same cycle -> DONE (capture rdata if read).
  - addr_ok alone -> DATA.
  - flush_except seen in ADDR sets abort flag; target becomes DRAIN instead of DATA/DONE.
- DATA: on data_ok, capture data_rdata into readdataM when read; go to DONE, or to IDLE if abort flag set (read data discarded).
  - flush_except in DATA -> DRAIN.
- DRAIN: wait data_ok, discard data, -> IDLE. No new request is accepted until then.
- DONE: -> IDLE when ~longest_stall; otherwise hold with no reissue. flush_except in DONE -> IDLE.
- stallreq_from_mem = (IDLE & access) | ADDR | DATA | DRAIN | (IDLE & |req_en & aborted-drain pending). It is 0 in DONE, so the M instruction advances exactly once.
- Minimum latency: access seen cycle 0, req cycle 1, addr_ok+data_ok cycle 1, DONE/stall low cycle 2.
- readdataM updates only on read completion; unchanged by writes.
- Reset values: state IDLE, data_req 0, data_wr 0, data_size 0, data_addr 0, data_wdata 0, readdataM 0, abort 0. stallreq_from_mem follows combinationally from state.
- Reset mid-transaction: returns to IDLE immediately; the slave is reset together.

Optional Feature:
DBRIDGE_PERF_CNT_EN:
- With it: adds outputs perf_rd_cnt[31:0], perf_wr_cnt[31:0], perf_stall_cnt[31:0].
  - rd/wr counters increment on each non-aborted completion.
  - stall counter increments each cycle stallreq_from_mem=1.
  - All counters saturate at 0xFFFF_FFFF and reset to 0.
- Without it: ports absent, no counter logic.

Decomposition:
- Package dbridge_pkg: state enum (IDLE/ADDR/DATA/DONE/DRAIN), size codes SZ_BYTE/SZ_HALF/SZ_WORD.
- One sub-module dbridge_perf_cnt (saturating counters), instantiated only under DBRIDGE_PERF_CNT_EN.

Test Plan:
- Word read addr 0x1000, slave addr_ok cycle 1, data_ok cycle 3 rdata 0xDEADBEEF -> stall high cycles 0-3, readdataM=0xDEADBEEF and stall low cycle 4, exactly one req accepted.
- Byte write writeEnM=4'b0010 addr 0x2001 data 0x0000AB00 -> data_wr=1, data_size=0, addr 0x2001, wdata held until addr_ok; readdataM unchanged.
- addr_ok and data_ok both in first req cycle -> DONE next cycle, total stall 2 cycles.
- Read completes while longest_stall=1 for 3 cycles -> stays DONE, stall low, data_req stays 0 (no reissue), IDLE after longest_stall drops.
- flush_except asserted in ADDR before addr_ok -> req held until addr_ok, then DRAIN until data_ok; readdataM unchanged; new access meanwhile stalls and issues after drain.
- Assert rst low in DATA -> asynchronously IDLE, data_req 0, readdataM 0; with DBRIDGE_PERF_CNT_EN, counters 0.
